mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single DRAM port between the Fetch instruction requester and the LSU data requester.
- Allows one outstanding memory transaction at a time.
- Sits between Fetch/LSU and DRAM, replacing the shared grant wire.
- Uses data-priority arbitration with a starvation guard for fetch, a response-routing state machine and a response timeout.

Parameters:
- MAX_DATA_STREAK, 4: consecutive data wins allowed while instr_req_ip is pending before fetch is forced to win.
- TIMEOUT_CYCLES, 64: cycles in WAIT_RESP without mem_rvalid_ip before the transaction is aborted.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- instr_req_ip  input  1  fetch request; held until instr_gnt_op
- instr_addr_ip  input  32  fetch address
- instr_gnt_op  output  1  fetch request accepted by memory (1-cycle pulse)
- instr_rvalid_op  output  1  fetch response valid (1-cycle pulse)
- instr_rdata_op  output  32  fetch response data
- data_req_ip  input  1  LSU request; held until data_gnt_op
- data_we_ip  input  1  1 = store, 0 = load
- data_be_ip  input  4  byte enables
- data_addr_ip  input  32  LSU address
- data_wdata_ip  input  32  store data
- data_gnt_op  output  1  LSU request accepted (1-cycle pulse)
- data_rvalid_op  output  1  LSU response valid (1-cycle pulse; also the store acknowledge)
- data_rdata_op  output  32  load data
- mem_req_op  output  1  request to DRAM
- mem_we_op  output  1  write enable to DRAM
- mem_be_op  output  4  byte enables to DRAM
- mem_addr_op  output  32  address to DRAM
- mem_wdata_op  output  32  write data to DRAM
- mem_gnt_ip  input  1  DRAM accepted request
- mem_rvalid_ip  input  1  DRAM response valid
- mem_rdata_ip  input  32  DRAM response data
- timeout_op  output  1  1-cycle pulse when a response times out

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, the streak counter is 0 and the timeout counter is 0.
  - Reset mid-transaction drops the transaction; no gnt or rvalid is issued for it.
  - mem_rvalid_ip seen in IDLE is ignored.
- States: IDLE, WAIT_GNT, WAIT_RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If either request is high, pick the winner, register owner plus mem_we/be/addr/wdata, then go to WAIT_GNT.
  - mem_req_op goes high the next cycle; arbitration costs 1 cycle.
  - If neither request is high, stay in IDLE.
- Arbitration rule:
  - Data wins over instr, except when instr_req_ip=1 and streak==MAX_DATA_STREAK; then instr wins.
  - Streak increments on a data win while instr_req_ip=1.
  - Streak clears on an instr win, or on any arbitration where instr_req_ip=0.
  - Streak saturates at MAX_DATA_STREAK.
- Instr-won transactions always drive mem_we_op=0 and mem_be_op=4'hF.
- WAIT_GNT:
  - mem_req_op=1 and the latched fields are held stable.
  - When mem_gnt_ip=1: pulse the owner's gnt in the same cycle (combinational: mem_gnt_ip AND owner), drop mem_req_op the next cycle, clear the timeout counter, go to WAIT_RESP.
  - WAIT_GNT has no timeout.
- WAIT_RESP:
  - The timeout counter increments each cycle.
  - On mem_rvalid_ip=1: register mem_rdata_ip into the owner's rdata and pulse the owner's rvalid the next cycle, then go to IDLE.
  - For stores, rdata is forced to 0.
  - If the counter reaches TIMEOUT_CYCLES first: pulse timeout_op, pulse the owner's rvalid with rdata=32'h0, go to IDLE.
- Back-to-back throughput: the cycle after the rvalid pulse is IDLE and can arbitrate. Minimum gap between transactions: rvalid cycle + 1 arbitration cycle.
- The non-owner's gnt and rvalid stay 0 throughout a transaction.
- rdata outputs hold their last value when rvalid is low.
- A request deasserted before its gnt is a protocol violation. The arbiter's latched copy still completes.
- Simultaneous data_req_ip and instr_req_ip in IDLE follow the arbitration rule above; the loser keeps its request high and is considered at the next IDLE.

Test Plan:
1. Single fetch: instr_req_ip=1, addr 0x10; DRAM grants 1 cycle after mem_req_op and returns 0x00500093 two cycles later → mem_addr_op=0x10, mem_we_op=0, instr_gnt_op pulses once, instr_rvalid_op pulses with instr_rdata_op=0x00500093, data_* outputs stay 0.
2. Simultaneous requests: instr addr 0x14 and data load addr 0x200 raised together → data transaction issued first (mem_addr_op=0x200), then fetch 0x14 issued at the next IDLE.
3. Starvation guard: instr_req_ip held high with data_req_ip continuously high → grant order is 4 data, then 1 instr, then 4 data; streak counter returns to 0 after the instr grant.
4. Store: data_we_ip=1, be=4'b0011, addr 0x204, wdata 0xCAFEBABE → mem_we_op=1, mem_be_op=4'b0011, mem_wdata_op=0xCAFEBABE; on mem_rvalid_ip with mem_rdata_ip=0xFFFFFFFF, data_rvalid_op pulses with data_rdata_op=0.
5. Timeout: grant given but mem_rvalid_ip never asserted → after 64 cycles in WAIT_RESP, timeout_op and data_rvalid_op pulse together with rdata=0, and the next pending request is arbitrated 1 cycle later.
6. Reset mid-operation: reset asserted for 1 cycle while in WAIT_RESP, then a late mem_rvalid_ip arrives → all outputs 0, no rvalid pulse to either requester, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Fetch/LSU/DRAM signal bundle seen by the memory arbiter.
// The arbiter attaches through the slave modport; the environment drives it through master.
interface mem_arbiter_if;
   logic        instr_req_ip;
   logic [31:0] instr_addr_ip;
   logic        instr_gnt_op;
   logic        instr_rvalid_op;
   logic [31:0] instr_rdata_op;

   logic        data_req_ip;
   logic        data_we_ip;
   logic [3:0]  data_be_ip;
   logic [31:0] data_addr_ip;
   logic [31:0] data_wdata_ip;
   logic        data_gnt_op;
   logic        data_rvalid_op;
   logic [31:0] data_rdata_op;

   logic        mem_req_op;
   logic        mem_we_op;
   logic [3:0]  mem_be_op;
   logic [31:0] mem_addr_op;
   logic [31:0] mem_wdata_op;
   logic        mem_gnt_ip;
   logic        mem_rvalid_ip;
   logic [31:0] mem_rdata_ip;

   logic        timeout_op;

   modport slave (
      input  instr_req_ip, instr_addr_ip,
      input  data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
      input  mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
      output instr_gnt_op, instr_rvalid_op, instr_rdata_op,
      output data_gnt_op, data_rvalid_op, data_rdata_op,
      output mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
      output timeout_op
   );

   modport master (
      output instr_req_ip, instr_addr_ip,
      output data_req_ip, data_we_ip, data_be_ip, data_addr_ip, data_wdata_ip,
      output mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
      input  instr_gnt_op, instr_rvalid_op, instr_rdata_op,
      input  data_gnt_op, data_rvalid_op, data_rdata_op,
      input  mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op,
      input  timeout_op
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding DRAM port arbiter between Fetch and LSU: data priority with a
// fetch starvation guard, owner-routed responses and a response timeout.
module mem_arbiter #(
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic          clock,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
   localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
   localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RESP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic                owner_data;
   logic [STREAK_W-1:0] streak;
   logic [STREAK_W-1:0] streak_nxt;
   logic [TMO_W-1:0]    tmo_cnt;

   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   logic        instr_rvalid;
   logic        data_rvalid;
   logic [31:0] instr_rdata;
   logic [31:0] data_rdata;
   logic        timeout;

   logic        arb_go;
   logic        data_wins;
   logic        gnt_hit;
   logic        resp_hit;
   logic        tmo_hit;
   logic        rsp_pulse;
   logic [31:0] rsp_data;

   // The rvalid cycle belongs to the finished transaction, so arbitration waits one more cycle.
   assign rsp_pulse = instr_rvalid | data_rvalid;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      streak_nxt = streak;
      arb_go     = 1'b0;
      data_wins  = 1'b0;
      gnt_hit    = 1'b0;
      resp_hit   = 1'b0;
      tmo_hit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rsp_pulse && (bus.instr_req_ip || bus.data_req_ip)) begin
               arb_go    = 1'b1;
               data_wins = bus.data_req_ip &&
                           !(bus.instr_req_ip && (streak == STREAK_MAX));
               if (!bus.instr_req_ip || !data_wins) begin
                  streak_nxt = '0;
               end else if (streak != STREAK_MAX) begin
                  streak_nxt = streak + 1'b1;
               end
               state_nxt = WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            if (bus.mem_gnt_ip) begin
               gnt_hit   = 1'b1;
               state_nxt = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            if (bus.mem_rvalid_ip) begin
               resp_hit  = 1'b1;
               state_nxt = IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               tmo_hit   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Stores and aborted transactions return zero data.
   assign rsp_data = (tmo_hit || (owner_data && mem_we)) ? 32'h0 : bus.mem_rdata_ip;

   always_ff @(posedge clock) begin
      if (reset) begin
         streak       <= '0;
         tmo_cnt      <= '0;
         owner_data   <= 1'b0;
         mem_we       <= 1'b0;
         mem_be       <= 4'h0;
         mem_addr     <= 32'h0;
         mem_wdata    <= 32'h0;
         instr_rvalid <= 1'b0;
         data_rvalid  <= 1'b0;
         instr_rdata  <= 32'h0;
         data_rdata   <= 32'h0;
         timeout      <= 1'b0;
      end else begin
         streak       <= streak_nxt;
         instr_rvalid <= (resp_hit || tmo_hit) && !owner_data;
         data_rvalid  <= (resp_hit || tmo_hit) && owner_data;
         timeout      <= tmo_hit;

         if (arb_go) begin
            owner_data <= data_wins;
            mem_we     <= data_wins && bus.data_we_ip;
            mem_be     <= data_wins ? bus.data_be_ip : 4'hF;
            mem_addr   <= data_wins ? bus.data_addr_ip : bus.instr_addr_ip;
            mem_wdata  <= data_wins ? bus.data_wdata_ip : 32'h0;
         end

         if (gnt_hit) begin
            tmo_cnt <= '0;
         end else if (state == WAIT_RESP) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end

         if (resp_hit || tmo_hit) begin
            if (owner_data) begin
               data_rdata <= rsp_data;
            end else begin
               instr_rdata <= rsp_data;
            end
         end
      end
   end

   // Grant is a combinational echo of the DRAM accept, routed to the owner only.
   assign bus.instr_gnt_op    = gnt_hit && !owner_data && !reset;
   assign bus.data_gnt_op     = gnt_hit && owner_data && !reset;
   assign bus.instr_rvalid_op = instr_rvalid;
   assign bus.instr_rdata_op  = instr_rdata;
   assign bus.data_rvalid_op  = data_rvalid;
   assign bus.data_rdata_op   = data_rdata;
   assign bus.mem_req_op      = (state == WAIT_GNT);
   assign bus.mem_we_op       = mem_we;
   assign bus.mem_be_op       = mem_be;
   assign bus.mem_addr_op     = mem_addr;
   assign bus.mem_wdata_op    = mem_wdata;
   assign bus.timeout_op      = timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of arbitration,
// grant/response routing, timeout and reset behaviour.
module tb_mem_arbiter;
   localparam int MAXS = 4;
   localparam int TMO  = 64;

   logic clock = 1'b0;
   logic reset;

   mem_arbiter_if bus();

   mem_arbiter #(.MAX_DATA_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // requesters
   bit          i_pend, d_pend, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_be;

   // stimulus knobs
   int p_instr, p_data, gnt_min, gnt_max, lat_min, lat_max, p_tmo, p_stray;
   bit          fix_en;
   logic [31:0] fix_rdata;

   // reference model of the transaction in flight
   bit          busy, granted, responded, tr_data, tr_we, tr_tmo, prev_rst;
   int          t_arb, t_gnt, t_resp, gnt_dly, resp_lat, streak, tmo_seen;
   logic [3:0]  tr_be;
   logic [31:0] tr_addr, tr_wdata, rsp_val, last_i, last_d;
   bit          glog[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      busy = 0; granted = 0; responded = 0; tr_tmo = 0;
      streak = 0; last_i = 32'h0; last_d = 32'h0;
      i_pend = 0; d_pend = 0;
      glog.delete();
   endtask

   task automatic arbitrate();
      bit dw;
      dw = d_pend && !(i_pend && streak == MAXS);
      if (dw && i_pend) streak = (streak < MAXS) ? streak + 1 : MAXS;
      else streak = 0;
      tr_data  = dw;
      tr_we    = dw ? d_we : 1'b0;
      tr_be    = dw ? d_be : 4'hF;
      tr_addr  = dw ? d_addr : i_addr;
      tr_wdata = d_wdata;
      busy = 1; granted = 0; responded = 0; tr_tmo = 0;
      t_arb    = cyc;
      gnt_dly  = $urandom_range(gnt_max, gnt_min);
      resp_lat = ($urandom_range(99) < p_tmo) ? -1 : $urandom_range(lat_max, lat_min);
   endtask

   task automatic step(input bit rst_now);
      bit exp_req, exp_pulse, gnt_now, rv_now;
      @(negedge clock);
      cyc++;
      if (!i_pend && $urandom_range(99) < p_instr) begin
         i_pend = 1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(99) < p_data) begin
         d_pend = 1; d_we = $urandom_range(1); d_be = 4'($urandom);
         d_addr = $urandom; d_wdata = $urandom;
      end
      gnt_now = !rst_now && busy && !granted && (cyc >= t_arb + 1 + gnt_dly);
      rv_now  = 0;
      if (busy && granted && !responded && resp_lat >= 0 && cyc == t_gnt + resp_lat) rv_now = 1;
      else if (!busy && $urandom_range(99) < p_stray) rv_now = 1;

      reset             = rst_now;
      bus.instr_req_ip  = i_pend;
      bus.instr_addr_ip = i_addr;
      bus.data_req_ip   = d_pend;
      bus.data_we_ip    = d_we;
      bus.data_be_ip    = d_be;
      bus.data_addr_ip  = d_addr;
      bus.data_wdata_ip = d_wdata;
      bus.mem_gnt_ip    = gnt_now;
      bus.mem_rvalid_ip = rv_now;
      bus.mem_rdata_ip  = fix_en ? fix_rdata : $urandom;
      #4;

      exp_req   = busy && !granted && (cyc > t_arb);
      exp_pulse = busy && responded && (cyc == t_resp + 1);
      if (exp_pulse) begin
         if (tr_data) last_d = rsp_val;
         else last_i = rsp_val;
      end
      if (bus.timeout_op === 1'b1) tmo_seen++;

      check_val("mem_req", 32'(bus.mem_req_op), 32'(exp_req));
      check_val("instr_gnt", 32'(bus.instr_gnt_op), 32'(exp_req && gnt_now && !tr_data));
      check_val("data_gnt", 32'(bus.data_gnt_op), 32'(exp_req && gnt_now && tr_data));
      check_val("instr_rvalid", 32'(bus.instr_rvalid_op), 32'(exp_pulse && !tr_data));
      check_val("data_rvalid", 32'(bus.data_rvalid_op), 32'(exp_pulse && tr_data));
      check_val("timeout", 32'(bus.timeout_op), 32'(exp_pulse && tr_tmo));
      check_val("instr_rdata", bus.instr_rdata_op, last_i);
      check_val("data_rdata", bus.data_rdata_op, last_d);
      if (exp_req) begin
         check_val("mem_we", 32'(bus.mem_we_op), 32'(tr_we));
         check_val("mem_be", 32'(bus.mem_be_op), 32'(tr_be));
         check_val("mem_addr", bus.mem_addr_op, tr_addr);
         if (tr_data) check_val("mem_wdata", bus.mem_wdata_op, tr_wdata);
      end
      if (prev_rst) begin
         check_val("rst_mem_req", 32'(bus.mem_req_op), 32'h0);
         check_val("rst_mem_we", 32'(bus.mem_we_op), 32'h0);
         check_val("rst_mem_be", 32'(bus.mem_be_op), 32'h0);
         check_val("rst_mem_addr", bus.mem_addr_op, 32'h0);
         check_val("rst_mem_wdata", bus.mem_wdata_op, 32'h0);
      end
      prev_rst = rst_now;

      if (rst_now) begin
         model_reset();
      end else if (exp_pulse) begin
         busy = 0;
      end else if (exp_req && gnt_now) begin
         granted = 1; t_gnt = cyc;
         glog.push_back(tr_data);
         if (tr_data) d_pend = 0;
         else i_pend = 0;
      end else if (busy && granted && !responded) begin
         if (rv_now) begin
            responded = 1; t_resp = cyc; tr_tmo = 0;
            rsp_val = (tr_data && tr_we) ? 32'h0 : bus.mem_rdata_ip;
         end else if (cyc == t_gnt + TMO) begin
            responded = 1; t_resp = cyc; tr_tmo = 1; rsp_val = 32'h0;
         end
      end else if (!busy && (i_pend || d_pend)) begin
         arbitrate();
      end
   endtask

   task automatic set_knobs(input int pi, input int pd, input int gmin, input int gmax,
                            input int lmin, input int lmax, input int pt, input int ps);
      p_instr = pi; p_data = pd; gnt_min = gmin; gnt_max = gmax;
      lat_min = lmin; lat_max = lmax; p_tmo = pt; p_stray = ps;
   endtask

   initial begin
      i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; d_we = 0;
      fix_en = 0; fix_rdata = 0; tmo_seen = 0; t_arb = 0; t_gnt = 0; t_resp = 0;
      gnt_dly = 0; resp_lat = 0; rsp_val = 0; tr_addr = 0; tr_wdata = 0; tr_be = 0;
      tr_data = 0; tr_we = 0;
      set_knobs(0, 0, 0, 0, 1, 1, 0, 0);
      model_reset();
      reset = 1;
      bus.instr_req_ip = 0; bus.instr_addr_ip = 0;
      bus.data_req_ip = 0; bus.data_we_ip = 0; bus.data_be_ip = 0;
      bus.data_addr_ip = 0; bus.data_wdata_ip = 0;
      bus.mem_gnt_ip = 0; bus.mem_rvalid_ip = 0; bus.mem_rdata_ip = 0;
      repeat (3) @(posedge clock);
      prev_rst = 1;

      // single fetch
      set_knobs(0, 0, 1, 1, 2, 2, 0, 0);
      fix_en = 1; fix_rdata = 32'h0050_0093;
      i_pend = 1; i_addr = 32'h10;
      repeat (10) step(0);
      check_val("t1_irdata", bus.instr_rdata_op, 32'h0050_0093);
      check_val("t1_drdata", bus.data_rdata_op, 32'h0);
      check_val("t1_grants", 32'(glog.size()), 32'd1);

      // simultaneous requests: data first, then fetch
      step(1);
      fix_en = 0;
      set_knobs(0, 0, 0, 2, 1, 3, 0, 0);
      i_pend = 1; i_addr = 32'h14;
      d_pend = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'h0;
      repeat (25) step(0);
      check_val("t2_grants", 32'(glog.size()), 32'd2);
      if (glog.size() >= 2) begin
         check_val("t2_first", 32'(glog[0]), 32'd1);
         check_val("t2_second", 32'(glog[1]), 32'd0);
      end

      // starvation guard: both always requesting
      step(1);
      set_knobs(100, 100, 0, 1, 1, 2, 0, 0);
      for (int k = 0; k < 400 && glog.size() < 10; k++) step(0);
      check_val("t3_count", 32'(glog.size() >= 10), 32'd1);
      for (int k = 0; k < 10 && k < glog.size(); k++)
         check_val("t3_order", 32'(glog[k]), 32'((k % 5) != 4));

      // load then store to the same word
      step(1);
      set_knobs(0, 0, 0, 1, 1, 2, 0, 0);
      fix_en = 1; fix_rdata = 32'hFFFF_FFFF;
      d_pend = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h204; d_wdata = 32'h0;
      repeat (10) step(0);
      check_val("t4_load", bus.data_rdata_op, 32'hFFFF_FFFF);
      d_pend = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h204; d_wdata = 32'hCAFE_BABE;
      repeat (10) step(0);
      check_val("t4_store", bus.data_rdata_op, 32'h0);

      // timeout on both owners in turn
      step(1);
      fix_en = 0;
      set_knobs(0, 0, 0, 0, 1, 1, 100, 0);
      tmo_seen = 0;
      d_pend = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300; d_wdata = 32'h0;
      i_pend = 1; i_addr = 32'h40;
      repeat (150) step(0);
      check_val("t5_timeouts", 32'(tmo_seen), 32'd2);

      // reset while waiting for a response, then a late response
      step(1);
      d_pend = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h400; d_wdata = 32'h0;
      repeat (10) step(0);
      step(1);
      set_knobs(0, 0, 0, 0, 1, 1, 0, 100);
      repeat (6) step(0);
      check_val("t6_irdata", bus.instr_rdata_op, 32'h0);
      check_val("t6_drdata", bus.data_rdata_op, 32'h0);

      // randomized traffic
      step(1);
      set_knobs(30, 40, 0, 3, 1, 4, 3, 10);
      repeat (3000) step(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
